osc_trigger_capture: RTL and testbench

Trigger-and-capture stage of the oscilloscope datapath. Sits directly downstream of the ADC sample interface inside `top`, at the 50 MHz system clock. Records ADC samples into an internal circular buffer, holds a programmable pre-trigger history and detects a level/edge trigger. Once the post-trigger window is full, it streams the frame out in time order over a valid/ready port to the display/DMA stage.

---
 rtl/osc_trigger_capture_if.sv | 13 +
 rtl/osc_trigger_capture.sv | 131 +++++++++++++
 tb/tb_osc_trigger_capture.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/osc_trigger_capture_if.sv
// osc_trigger_capture_if: ADC sample input and frame readout valid/ready port.
interface osc_trigger_capture_if #(
    parameter int DW = 8
);
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    modport slave (input adc_data, adc_valid, rd_ready, output rd_data, rd_valid, rd_last);
    modport master (output adc_data, adc_valid, rd_ready, input rd_data, rd_valid, rd_last);
endinterface

// File: rtl/osc_trigger_capture.sv
// osc_trigger_capture: circular pre/post-trigger sample capture with level/edge trigger
// and time-ordered frame readout through a 2-entry skid buffer.
module osc_trigger_capture #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    osc_trigger_capture_if.slave  bus,
    input  logic                  i_arm,
    input  logic [DW-1:0]         i_trig_level,
    input  logic                  i_trig_edge,
    input  logic [AW-1:0]         i_pre_depth,
    input  logic                  i_force_trig,
    output logic [2:0]            o_state,
    output logic                  o_triggered,
    output logic                  o_done
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, WAIT = 3'd2, POST = 3'd3, READ = 3'd4} state_t;
    state_t        r_state;
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_raddr, r_pre;
    logic [AW:0]   r_cnt;
    logic [DW-1:0] r_level, r_prev, r_q;
    logic          r_edge, r_hist, r_pend, r_qv, r_ql, r_triggered, r_done;
    logic [DW:0]   r_fifo [2];
    logic [1:0]    r_fcnt;
    logic          w_we, w_cmp, w_trig, w_pop, w_issue;
    logic [AW:0]   w_post, w_cnt1;
    logic [2:0]    w_room;
    logic [1:0]    w_pidx;
    assign w_we = bus.adc_valid && (r_state == PRE || r_state == WAIT || r_state == POST);
    assign w_cmp = r_edge ? (r_prev > r_level && bus.adc_data <= r_level)
                          : (r_prev < r_level && bus.adc_data >= r_level);
    assign w_trig = r_state == WAIT && bus.adc_valid && ((r_hist && w_cmp) || i_force_trig || r_pend);
    assign w_post = FULL - {1'b0, r_pre};
    assign w_cnt1 = r_cnt + 1'b1;
    assign w_pop = bus.rd_valid && bus.rd_ready;
    // Skid occupancy after this edge, counting the read already in flight from the RAM.
    assign w_room = {1'b0, r_fcnt} + {2'b0, r_qv} - {2'b0, w_pop};
    assign w_pidx = r_fcnt - {1'b0, w_pop};
    assign w_issue = r_state == READ && r_cnt != FULL && w_room < 3'd2;
    assign bus.rd_valid = r_fcnt != 2'd0;
    assign bus.rd_data = r_fifo[0][DW-1:0];
    assign bus.rd_last = r_fifo[0][DW] && r_fcnt != 2'd0;
    assign o_state = r_state;
    assign o_triggered = r_triggered;
    assign o_done = r_done;
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wptr] <= bus.adc_data;
        r_q <= r_mem[r_raddr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_raddr     <= '0;
            r_pre       <= '0;
            r_cnt       <= '0;
            r_level     <= '0;
            r_prev      <= '0;
            r_edge      <= 1'b0;
            r_hist      <= 1'b0;
            r_pend      <= 1'b0;
            r_qv        <= 1'b0;
            r_ql        <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_fcnt      <= '0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
        end else begin
            r_triggered <= w_trig;
            r_done      <= 1'b0;
            r_qv        <= w_issue;
            r_ql        <= w_issue && w_cnt1 == FULL;
            r_fcnt      <= w_room[1:0];
            if (w_pop) r_fifo[0] <= r_fifo[1];
            if (r_qv) r_fifo[w_pidx[0]] <= {r_ql, r_q};
            if (w_we) begin
                r_wptr <= r_wptr + 1'b1;
                r_prev <= bus.adc_data;
                r_hist <= 1'b1;
            end
            unique case (r_state)
                IDLE: if (i_arm) begin
                    r_level <= i_trig_level;
                    r_edge  <= i_trig_edge;
                    r_pre   <= i_pre_depth;
                    r_wptr  <= '0;
                    r_cnt   <= '0;
                    r_hist  <= 1'b0;
                    r_pend  <= 1'b0;
                    r_state <= i_pre_depth == '0 ? WAIT : PRE;
                end
                PRE: if (bus.adc_valid) begin
                    r_cnt <= w_cnt1;
                    if (w_cnt1 == {1'b0, r_pre}) r_state <= WAIT;
                end
                // The frame start (trigger address - pre_depth) is the slot after the final write.
                WAIT: if (w_trig) begin
                    r_pend  <= 1'b0;
                    r_raddr <= r_wptr + 1'b1;
                    r_cnt   <= w_post == (AW+1)'(1) ? '0 : (AW+1)'(1);
                    r_state <= w_post == (AW+1)'(1) ? READ : POST;
                end else if (i_force_trig) begin
                    r_pend <= 1'b1;
                end
                POST: if (bus.adc_valid) begin
                    r_raddr <= r_wptr + 1'b1;
                    r_cnt   <= w_cnt1 == w_post ? '0 : w_cnt1;
                    r_state <= w_cnt1 == w_post ? READ : POST;
                end
                READ: begin
                    if (w_issue) begin
                        r_raddr <= r_raddr + 1'b1;
                        r_cnt   <= w_cnt1;
                    end
                    if (w_pop && bus.rd_last) begin
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_osc_trigger_capture.sv
// tb_osc_trigger_capture: directed scenarios for the trigger/capture stage at AW=4 (16-sample frames).
module tb_osc_trigger_capture;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_arm = 1'b0;
    logic [7:0] i_trig_level = '0;
    logic       i_trig_edge = 1'b0;
    logic [3:0] i_pre_depth = '0;
    logic       i_force_trig = 1'b0;
    logic [2:0] o_state;
    logic       o_triggered, o_done;
    int errors = 0;
    int checks = 0;
    logic [7:0] sd[$];
    bit sv[$], sf[$];
    logic [7:0] rx[$];
    int ntrig, trig_idx, last_pos, first_xfer, last_xfer, ndone, done_bad, nunst;
    logic [7:0] trig_val;

    osc_trigger_capture_if #(.DW(8)) bus();

    osc_trigger_capture #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .i_arm(i_arm), .i_trig_level(i_trig_level),
        .i_trig_edge(i_trig_edge), .i_pre_depth(i_pre_depth), .i_force_trig(i_force_trig),
        .o_state(o_state), .o_triggered(o_triggered), .o_done(o_done)
    );

    always #10 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task push(input logic [7:0] d, input bit v, input bit f);
        sd.push_back(d);
        sv.push_back(v);
        sf.push_back(f);
    endtask

    // Arms a capture, then scrambles the config inputs so only latched values can matter.
    task arm_cfg(input logic [7:0] lvl, input logic edg, input logic [3:0] pre);
        i_arm = 1'b1;
        i_trig_level = lvl;
        i_trig_edge = edg;
        i_pre_depth = pre;
        tick;
        i_arm = 1'b0;
        i_trig_level = ~lvl;
        i_trig_edge = ~edg;
        i_pre_depth = ~pre;
    endtask

    task feed(input int stop);
        ntrig = 0;
        trig_idx = -1;
        trig_val = '0;
        for (int i = 0; i < sd.size(); i++) begin
            bus.adc_valid = sv[i];
            bus.adc_data = sd[i];
            i_force_trig = sf[i];
            tick;
            if (o_triggered) begin
                ntrig++;
                trig_idx = i;
                trig_val = sd[i];
            end
            if (o_state == 3'(stop)) break;
        end
        bus.adc_valid = 1'b0;
        i_force_trig = 1'b0;
        sd.delete();
        sv.delete();
        sf.delete();
    endtask

    task collect(input int pat);
        logic [7:0] held;
        logic hl;
        bit stalled;
        stalled = 0;
        held = '0;
        hl = 1'b0;
        rx.delete();
        last_pos = -1;
        first_xfer = -1;
        last_xfer = -10;
        ndone = 0;
        done_bad = 0;
        nunst = 0;
        for (int c = 0; c < 300; c++) begin
            bus.rd_ready = pat == 0 ? 1'b1 : (c % 3 == 0);
            if (stalled && (bus.rd_valid !== 1'b1 || bus.rd_data !== held || bus.rd_last !== hl)) nunst++;
            stalled = bus.rd_valid && !bus.rd_ready;
            held = bus.rd_data;
            hl = bus.rd_last;
            if (bus.rd_valid && bus.rd_ready) begin
                if (first_xfer < 0) first_xfer = c;
                rx.push_back(bus.rd_data);
                if (bus.rd_last === 1'b1 && last_pos < 0) begin
                    last_pos = rx.size() - 1;
                    last_xfer = c;
                end
            end
            tick;
            if (o_done) begin
                ndone++;
                if (c != last_xfer) done_bad++;
            end
            if (last_xfer >= 0 && c >= last_xfer + 3) break;
        end
        bus.rd_ready = 1'b0;
    endtask

    task test_reset;
        rst = 1'b1;
        repeat (3) tick;
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        checks++; if ({bus.rd_valid, bus.rd_last, o_triggered, o_done} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.rd_valid, bus.rd_last, o_triggered, o_done}); end
        checks++; if (bus.rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", bus.rd_data); end
        rst = 1'b0;
        tick;
    endtask

    task test_pre0;
        arm_cfg(8'd128, 1'b0, 4'd0);
        checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL pre0_wait: got %0d expected 2", o_state); end
        push(8'd200, 1, 0); push(8'd200, 1, 0); push(8'd50, 1, 0); push(8'd200, 1, 0);
        for (int k = 0; k < 20; k++) push(8'(10 + k), 1, 0);
        feed(4);
        checks++; if (ntrig !== 1 || trig_idx !== 3) begin errors++; $display("FAIL pre0_trigger: got count %0d idx %0d expected 1 idx 3", ntrig, trig_idx); end
        collect(0);
        checks++; if (rx.size() !== 16) begin errors++; $display("FAIL pre0_size: got %0d expected 16", rx.size()); end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            checks++; if (rx[i] !== (i == 0 ? 8'd200 : 8'(9 + i))) begin errors++; $display("FAIL pre0_data[%0d]: got %0d expected %0d", i, rx[i], (i == 0 ? 200 : 9 + i)); end
        end
    endtask

    task test_ramp(input int pat, input bit rst_mid);
        arm_cfg(8'd128, 1'b0, 4'd4);
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL ramp_pre: got %0d expected 1", o_state); end
        for (int k = 0; k < 32; k++) push(8'(8 * k), 1, 0);
        if (rst_mid) begin
            feed(3);
            checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL rst_post_reached: got %0d expected 3", o_state); end
            rst = 1'b1;
            tick;
            checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", o_state); end
            checks++; if ({bus.rd_valid, bus.rd_last, o_triggered, o_done, bus.rd_data} !== 12'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0", {bus.rd_valid, bus.rd_last, o_triggered, o_done, bus.rd_data}); end
            rst = 1'b0;
            tick;
            return;
        end
        feed(4);
        checks++; if (ntrig !== 1 || trig_val !== 8'd128) begin errors++; $display("FAIL ramp_trigger: got count %0d value %0d expected 1 value 128", ntrig, trig_val); end
        checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL ramp_read: got %0d expected 4", o_state); end
        collect(pat);
        checks++; if (rx.size() !== 16) begin errors++; $display("FAIL ramp_size: got %0d expected 16", rx.size()); end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            checks++; if (rx[i] !== 8'(96 + 8 * i)) begin errors++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, rx[i], 96 + 8 * i); end
        end
        checks++; if (last_pos !== 15) begin errors++; $display("FAIL ramp_last: got %0d expected 15", last_pos); end
        checks++; if (ndone !== 1 || done_bad !== 0) begin errors++; $display("FAIL ramp_done: got %0d pulses %0d late expected 1 0", ndone, done_bad); end
        checks++; if (nunst !== 0) begin errors++; $display("FAIL ramp_stall_stable: got %0d changes expected 0", nunst); end
        checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL ramp_idle: got %0d expected 0", o_state); end
        if (pat == 0) begin
            checks++; if (first_xfer > 2 || last_xfer - first_xfer !== 15) begin errors++; $display("FAIL ramp_throughput: got first %0d span %0d expected <=2 and 15", first_xfer, last_xfer - first_xfer); end
        end
    endtask

    task test_falling;
        arm_cfg(8'd100, 1'b1, 4'd2);
        for (int k = 0; k < 32; k++) push(8'(200 - 10 * k), 1, 0);
        feed(4);
        checks++; if (ntrig !== 1 || trig_val !== 8'd100) begin errors++; $display("FAIL fall_trigger: got count %0d value %0d expected 1 value 100", ntrig, trig_val); end
        collect(0);
        checks++; if (rx.size() !== 16) begin errors++; $display("FAIL fall_size: got %0d expected 16", rx.size()); end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            checks++; if (rx[i] !== 8'(120 - 10 * i)) begin errors++; $display("FAIL fall_data[%0d]: got %0d expected %0d", i, rx[i], 8'(120 - 10 * i)); end
        end
    endtask

    task test_force;
        int bad;
        arm_cfg(8'd128, 1'b0, 4'd4);
        push(8'd50, 1, 1);
        for (int k = 0; k < 5; k++) push(8'd50, 1, 0);
        push(8'd50, 0, 1); push(8'd50, 0, 0);
        for (int k = 0; k < 20; k++) push(8'd50, 1, 0);
        feed(4);
        checks++; if (ntrig !== 1 || trig_idx !== 8) begin errors++; $display("FAIL force_trigger: got count %0d idx %0d expected 1 idx 8", ntrig, trig_idx); end
        collect(0);
        bad = 0;
        foreach (rx[i]) if (rx[i] !== 8'd50) bad++;
        checks++; if (rx.size() !== 16 || bad !== 0) begin errors++; $display("FAIL force_frame: got %0d samples %0d wrong expected 16 0", rx.size(), bad); end
    endtask

    task test_pre_max;
        arm_cfg(8'd128, 1'b0, 4'd15);
        for (int k = 0; k < 24; k++) push(8'(8 * k), 1, 0);
        feed(4);
        checks++; if (ntrig !== 1 || trig_idx !== 16 || o_state !== 3'd4) begin errors++; $display("FAIL premax_trigger: got count %0d idx %0d state %0d expected 1 16 4", ntrig, trig_idx, o_state); end
        collect(0);
        checks++; if (rx.size() !== 16) begin errors++; $display("FAIL premax_size: got %0d expected 16", rx.size()); end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            checks++; if (rx[i] !== 8'(8 + 8 * i)) begin errors++; $display("FAIL premax_data[%0d]: got %0d expected %0d", i, rx[i], 8 + 8 * i); end
        end
    endtask

    initial begin
        bus.adc_data = '0;
        bus.adc_valid = 1'b0;
        bus.rd_ready = 1'b0;
        test_reset;
        test_pre0;
        test_ramp(0, 0);
        test_falling;
        test_force;
        test_ramp(1, 0);
        test_pre_max;
        test_ramp(0, 1);
        test_ramp(0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
